// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 codes, FSM state encoding and size/mask helpers shared by
// the LSU memory sequencer and its lane-align datapath.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [31:0] MASK_B = 32'h0000_00FF;
    localparam logic [31:0] MASK_H = 32'h0000_FFFF;
    localparam logic [31:0] MASK_W = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD0  = 3'd1,
        RD1  = 3'd2,
        WR0  = 3'd3,
        WR1  = 3'd4,
        DONE = 3'd5
    } lsu_state_e;

    function automatic logic f3_legal(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    // Access size in bytes; funct3[2] only selects sign vs zero extension.
    function automatic logic [2:0] size_bytes(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [31:0] size_mask(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return MASK_B;
            2'b01:   return MASK_H;
            default: return MASK_W;
        endcase
    endfunction

    // True when the byte offset is not a multiple of the access size.
    function automatic logic off_misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   return 1'b0;
            2'b01:   return off[0];
            default: return off != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational byte-lane datapath. Works on the 64-bit
// window {buf1, buf0} so that accesses straddling a word boundary merge and
// extract exactly like aligned ones.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [63:0] buf_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] merged_lo_o,
    output logic [31:0] merged_hi_o,
    output logic [31:0] load_o
);

    logic [5:0]  sh;
    logic [63:0] mask64;
    logic [63:0] merged;
    logic [31:0] raw;

    assign sh          = {off_i, 3'b000};
    assign mask64      = {32'h0, size_mask(funct3_i)};
    assign merged      = (buf_i & ~(mask64 << sh)) | (({32'h0, wdata_i} & mask64) << sh);
    assign merged_lo_o = merged[31:0];
    assign merged_hi_o = merged[63:32];
    assign raw         = 32'(buf_i >> sh) & size_mask(funct3_i);

    // Sign-extend B/H loads, zero-extend BU/HU (already masked) and W.
    always_comb begin
        case (funct3_i)
            F3_B:    load_o = {{24{raw[7]}}, raw[7:0]};
            F3_H:    load_o = {{16{raw[15]}}, raw[15:0]};
            default: load_o = raw;
        endcase
    end

endmodule

// File: rtl/lsu_mem_sequencer.sv
// lsu_mem_sequencer: turns RV32I loads/stores into whole-word memory reads
// and writes (read-modify-write for sub-word stores), stalling via busy.
// Optional macro LSU_MISALIGN_SPLIT_EN: when defined, accesses crossing a
// word boundary are split over two words; when undefined they end in DONE
// with misalign_err=1 and no memory traffic.
//
// state | meaning
// IDLE  | waiting for req_valid, request latched on accept
// RD0   | read low word w0 into buf0
// RD1   | read high word w1 into buf1 (crossing access only)
// WR0   | write merged low word to w0
// WR1   | write merged high word to w1 (crossing store only)
// DONE  | one-cycle resp_valid pulse
module lsu_mem_sequencer
    import lsu_pkg::*;
#(
    parameter int Width        = 32,
    parameter int MemDepthLog2 = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    input  logic             req_we,
    input  logic [2:0]       req_funct3,
    input  logic [Width-1:0] req_addr,
    input  logic [Width-1:0] req_wdata,
    output logic             busy,
    output logic             resp_valid,
    output logic [Width-1:0] resp_rdata,
    output logic             misalign_err,
    output logic             mem_read,
    output logic             mem_write,
    output logic [Width-1:0] mem_addr,
    output logic [Width-1:0] mem_wdata,
    input  logic [Width-1:0] mem_rdata
);

    localparam int AW = MemDepthLog2;

    lsu_state_e       state_q, state_d;
    logic             we_q, we_d;
    logic [2:0]       f3_q, f3_d;
    logic [1:0]       off_q, off_d;
    logic [AW-1:0]    w0_q, w0_d, w1_q, w1_d;
    logic             span_q, span_d;
    logic             err_q, err_d;
    logic [Width-1:0] wdata_q, wdata_d;
    logic [Width-1:0] buf0_q, buf0_d, buf1_q, buf1_d;

    logic             busy_q, busy_d, resp_valid_q, resp_valid_d, misalign_q, misalign_d;
    logic             mem_read_q, mem_read_d, mem_write_q, mem_write_d;
    logic [Width-1:0] resp_rdata_q, resp_rdata_d, mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;

    logic [1:0]       req_off;
    logic [AW-1:0]    req_w0;
    logic             req_span, req_bad, req_full_sw;
    logic [Width-1:0] merged_lo, merged_hi, load_ext;
    logic             unused_addr_hi;

    assign req_off     = req_addr[1:0];
    assign req_w0      = req_addr[AW+1:2];
    assign req_span    = ({1'b0, req_off} + size_bytes(req_funct3)) > 3'd4;
    assign req_full_sw = req_we && (req_funct3 == F3_W) && (req_off == 2'b00);
`ifdef LSU_MISALIGN_SPLIT_EN
    assign req_bad     = !f3_legal(req_funct3);
`else
    assign req_bad     = !f3_legal(req_funct3) || off_misaligned(req_funct3, req_off);
`endif
    assign unused_addr_hi = ^req_addr[Width-1:AW+2];

    // Lane datapath sees next-cycle buffers so the write data can be registered
    // together with the strobe, and the load result together with resp_valid.
    lsu_lane_align u_lane_align (
        .buf_i       ({buf1_d, buf0_d}),
        .off_i       (off_d),
        .funct3_i    (f3_d),
        .wdata_i     (wdata_d),
        .merged_lo_o (merged_lo),
        .merged_hi_o (merged_hi),
        .load_o      (load_ext)
    );

    // Next-state, request latching and next registered outputs.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        f3_d    = f3_q;
        off_d   = off_q;
        w0_d    = w0_q;
        w1_d    = w1_q;
        span_d  = span_q;
        err_d   = err_q;
        wdata_d = wdata_q;
        buf0_d  = buf0_q;
        buf1_d  = buf1_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    off_d   = req_off;
                    w0_d    = req_w0;
                    w1_d    = req_w0 + AW'(1);
                    span_d  = req_span;
                    wdata_d = req_wdata;
                    buf0_d  = '0;
                    buf1_d  = '0;
                    err_d   = req_bad;
                    if (req_bad)          state_d = DONE;
                    else if (req_full_sw) state_d = WR0;
                    else                  state_d = RD0;
                end
            end
            RD0: begin
                buf0_d = mem_rdata;
                if (span_q)    state_d = RD1;
                else if (we_q) state_d = WR0;
                else           state_d = DONE;
            end
            RD1: begin
                buf1_d  = mem_rdata;
                state_d = we_q ? WR0 : DONE;
            end
            WR0:     state_d = span_q ? WR1 : DONE;
            WR1:     state_d = DONE;
            default: state_d = IDLE;
        endcase

        busy_d       = (state_d != IDLE);
        mem_read_d   = (state_d == RD0) || (state_d == RD1);
        mem_write_d  = (state_d == WR0) || (state_d == WR1);
        resp_valid_d = (state_d == DONE);
        misalign_d   = (state_d == DONE) && err_d;
        resp_rdata_d = ((state_d == DONE) && !we_d && !err_d) ? load_ext : '0;
        case (state_d)
            RD0, WR0: mem_addr_d = {{(Width-AW){1'b0}}, w0_d};
            RD1, WR1: mem_addr_d = {{(Width-AW){1'b0}}, w1_d};
            default:  mem_addr_d = '0;
        endcase
        case (state_d)
            WR0:     mem_wdata_d = merged_lo;
            WR1:     mem_wdata_d = merged_hi;
            default: mem_wdata_d = '0;
        endcase
    end

    // State, latched request, buffers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            f3_q         <= '0;
            off_q        <= '0;
            w0_q         <= '0;
            w1_q         <= '0;
            span_q       <= 1'b0;
            err_q        <= 1'b0;
            wdata_q      <= '0;
            buf0_q       <= '0;
            buf1_q       <= '0;
            busy_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            misalign_q   <= 1'b0;
            resp_rdata_q <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            f3_q         <= f3_d;
            off_q        <= off_d;
            w0_q         <= w0_d;
            w1_q         <= w1_d;
            span_q       <= span_d;
            err_q        <= err_d;
            wdata_q      <= wdata_d;
            buf0_q       <= buf0_d;
            buf1_q       <= buf1_d;
            busy_q       <= busy_d;
            resp_valid_q <= resp_valid_d;
            misalign_q   <= misalign_d;
            resp_rdata_q <= resp_rdata_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign busy         = busy_q;
    assign resp_valid   = resp_valid_q;
    assign resp_rdata   = resp_rdata_q;
    assign misalign_err = misalign_q;
    assign mem_read     = mem_read_q;
    assign mem_write    = mem_write_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_sequencer.sv
// tb_lsu_mem_sequencer: directed vector table, reset-abandon sequence and
// randomized accesses checked against a byte-array memory model.
module tb_lsu_mem_sequencer;

`ifdef LSU_MISALIGN_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        busy, resp_valid, misalign_err, mem_read, mem_write;
    logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;

    logic [31:0] mem [512];
    logic [7:0]  ref_mem [2048];
    logic        mem_init;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    lsu_mem_sequencer #(.Width(32), .MemDepthLog2(9)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_we       (req_we),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .busy         (busy),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .misalign_err (misalign_err),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    assign mem_rdata = mem[mem_addr[8:0]];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int k = 0; k < 512; k++) mem[k] <= 32'(k);
        end else if (mem_write) begin
            mem[mem_addr[8:0]] <= mem_wdata;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check("strobe_exclusive", 32'(mem_read & mem_write), 32'h0);
            if (!mem_read && !mem_write) check("idle_bus_zero", mem_addr | mem_wdata, 32'h0);
            check("mem_addr_range", mem_addr >> 9, 32'h0);
        end
    end

    // Reference: byte-addressed memory, little-endian, addresses modulo 2 KiB.
    function automatic void model(input logic we, input logic [2:0] f3,
                                  input logic [31:0] addr, input logic [31:0] wd,
                                  output logic [31:0] rd, output logic err,
                                  output int lat, output int nrd, output int nwr);
        int size, off, a;
        bit span, legal;
        rd = 0; err = 0; lat = 0; nrd = 0; nwr = 0;
        legal = 1'b1;
        case (f3)
            3'b000, 3'b100: size = 1;
            3'b001, 3'b101: size = 2;
            3'b010:         size = 4;
            default: begin size = 1; legal = 1'b0; end
        endcase
        off  = int'(addr & 32'h3);
        a    = int'(addr & 32'h7FF);
        span = (off + size) > 4;
        if (!legal || (!SPLIT && (off % size) != 0)) begin
            err = 1'b1; lat = 1;
            return;
        end
        if (!we) begin
            for (int i = 0; i < size; i++) rd |= 32'(ref_mem[(a + i) % 2048]) << (8 * i);
            if (f3 == 3'b000 && rd[7])  rd |= 32'hFFFF_FF00;
            if (f3 == 3'b001 && rd[15]) rd |= 32'hFFFF_0000;
            nrd = span ? 2 : 1;
            lat = span ? 3 : 2;
        end else begin
            for (int i = 0; i < size; i++) ref_mem[(a + i) % 2048] = 8'(wd >> (8 * i));
            if (size == 4 && off == 0) begin
                nwr = 1; lat = 2;
            end else begin
                nrd = span ? 2 : 1; nwr = nrd; lat = span ? 5 : 3;
            end
        end
    endfunction

    // Issue one request from IDLE and watch it to resp_valid (bounded).
    task automatic run_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wd, output logic [31:0] rd, output logic err,
                              output int lat, output int nrd, output int nwr);
        int guard;
        rd = 0; err = 0; lat = 0; nrd = 0; nwr = 0;
        guard = 0;
        while (busy && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check("idle_before_req", 32'(busy), 32'h0);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        @(posedge clk); #1;
        for (int c = 1; c <= 12; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            nrd += int'(mem_read);
            nwr += int'(mem_write);
            if (resp_valid) begin
                lat = c; rd = resp_rdata; err = misalign_err;
                break;
            end
            // Junk while busy must be ignored.
            req_valid  = 1'b1;
            req_we     = 1'($urandom_range(0, 1));
            req_funct3 = 3'($urandom_range(0, 7));
            req_addr   = $urandom();
            req_wdata  = $urandom();
        end
        req_valid = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          nrd;
        int          nwr;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] rd, input logic err,
                       input int lat, input int nrd, input int nwr);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wd; v.rdata = rd;
        v.err = err; v.lat = lat; v.nrd = nrd; v.nwr = nwr;
        vecs.push_back(v);
    endtask

    task automatic check_access(input string tag, input logic [31:0] rd, input logic err,
                                input int lat, input int nrd, input int nwr,
                                input logic [31:0] e_rd, input logic e_err,
                                input int e_lat, input int e_nrd, input int e_nwr);
        check({tag, " rdata"}, rd, e_rd);
        check({tag, " misalign_err"}, 32'(err), 32'(e_err));
        check({tag, " latency"}, 32'(lat), 32'(e_lat));
        check({tag, " reads"}, 32'(nrd), 32'(e_nrd));
        check({tag, " writes"}, 32'(nwr), 32'(e_nwr));
    endtask

    initial begin
        logic [31:0] g_rd, e_rd;
        logic        g_err, e_err;
        int          g_lat, g_nrd, g_nwr, e_lat, e_nrd, e_nwr;
        int          hits, nbad;
        logic        r_we;
        logic [2:0]  r_f3;
        logic [31:0] r_addr, r_wd;

        rst_n = 1'b0; mem_init = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
        for (int b = 0; b < 2048; b++) ref_mem[b] = 8'(b / 4 >> (8 * (b % 4)));
        repeat (3) @(posedge clk);
        #1;
        check("rst busy", 32'(busy), 32'h0);
        check("rst resp_valid", 32'(resp_valid), 32'h0);
        check("rst resp_rdata", resp_rdata, 32'h0);
        check("rst misalign_err", 32'(misalign_err), 32'h0);
        check("rst mem_read", 32'(mem_read), 32'h0);
        check("rst mem_write", 32'(mem_write), 32'h0);
        check("rst mem_addr", mem_addr, 32'h0);
        check("rst mem_wdata", mem_wdata, 32'h0);
        mem_init = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        //  we  f3      addr          wdata          rdata                                err   lat          rd           wr
        add(0, 3'b010, 32'h0000_000C, 32'h0,          32'h0000_0003,                       0,    2,           1,           0);
        add(1, 3'b010, 32'h0000_0010, 32'h80FF_7F01,  32'h0,                               0,    2,           0,           1);
        add(0, 3'b000, 32'h0000_0011, 32'h0,          32'h0000_007F,                       0,    2,           1,           0);
        add(0, 3'b000, 32'h0000_0013, 32'h0,          32'hFFFF_FF80,                       0,    2,           1,           0);
        add(0, 3'b100, 32'h0000_0013, 32'h0,          32'h0000_0080,                       0,    2,           1,           0);
        add(0, 3'b101, 32'h0000_0012, 32'h0,          32'h0000_80FF,                       0,    2,           1,           0);
        add(1, 3'b000, 32'h0000_0012, 32'h0000_00AA,  32'h0,                               0,    3,           1,           1);
        add(0, 3'b010, 32'h0000_0010, 32'h0,          32'h80AA_7F01,                       0,    2,           1,           0);
        add(0, 3'b001, 32'h0000_0012, 32'h0,          32'hFFFF_80AA,                       0,    2,           1,           0);
        add(0, 3'b010, 32'h0000_000E, 32'h0,          SPLIT ? 32'h7F01_0000 : 32'h0,       !SPLIT, SPLIT ? 3 : 1, SPLIT ? 2 : 0, 0);
        add(0, 3'b011, 32'h0000_0020, 32'h0,          32'h0,                               1,    1,           0,           0);
        add(1, 3'b111, 32'h0000_0020, 32'hFFFF_FFFF,  32'h0,                               1,    1,           0,           0);
        add(0, 3'b001, 32'h0000_0003, 32'h0,          SPLIT ? 32'h0000_0100 : 32'h0,       !SPLIT, SPLIT ? 3 : 1, SPLIT ? 2 : 0, 0);
        add(1, 3'b001, 32'h0000_07FF, 32'h0000_BEEF,  32'h0,                               !SPLIT, SPLIT ? 5 : 1, SPLIT ? 2 : 0, SPLIT ? 2 : 0);
        add(0, 3'b100, 32'h0000_07FF, 32'h0,          SPLIT ? 32'h0000_00EF : 32'h0,       0,    2,           1,           0);
        add(0, 3'b010, 32'h0000_0000, 32'h0,          SPLIT ? 32'h0000_00BE : 32'h0,       0,    2,           1,           0);
        add(0, 3'b010, 32'h0000_07FC, 32'h0,          SPLIT ? 32'hEF00_01FF : 32'h0000_01FF, 0,  2,           1,           0);
        add(0, 3'b101, 32'h0000_0011, 32'h0,          SPLIT ? 32'h0000_AA7F : 32'h0,       !SPLIT, SPLIT ? 2 : 1, SPLIT ? 1 : 0, 0);
        add(1, 3'b010, 32'h0000_0016, 32'h1234_5678,  32'h0,                               !SPLIT, SPLIT ? 5 : 1, SPLIT ? 2 : 0, SPLIT ? 2 : 0);
        add(0, 3'b010, 32'h0000_0014, 32'h0,          SPLIT ? 32'h5678_0005 : 32'h0000_0005, 0,  2,           1,           0);
        add(1, 3'b001, 32'h0000_001A, 32'h0000_CAFE,  32'h0,                               0,    3,           1,           1);
        add(0, 3'b010, 32'h0000_0018, 32'h0,          SPLIT ? 32'hCAFE_1234 : 32'hCAFE_0006, 0,  2,           1,           0);

        foreach (vecs[i]) begin
            run_access(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
                       g_rd, g_err, g_lat, g_nrd, g_nwr);
            model(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
                  e_rd, e_err, e_lat, e_nrd, e_nwr);
            check_access($sformatf("vec%0d", i), g_rd, g_err, g_lat, g_nrd, g_nwr,
                         vecs[i].rdata, vecs[i].err, vecs[i].lat, vecs[i].nrd, vecs[i].nwr);
        end

        // Reset in the middle of a store: RD1 of a crossing SW when splitting,
        // otherwise RD0 of an SB. Nothing may be written or answered.
        while (busy) begin @(posedge clk); #1; end
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0000_0021; req_wdata = 32'hDEAD_BEEF;
        req_funct3 = SPLIT ? 3'b010 : 3'b000;
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (SPLIT) begin @(posedge clk); #1; end
        check("abort pre mem_read", 32'(mem_read), 32'h1);
        check("abort pre mem_addr", mem_addr, SPLIT ? 32'h9 : 32'h8);
        rst_n = 1'b0;
        #1;
        check("abort mem_read", 32'(mem_read), 32'h0);
        check("abort mem_write", 32'(mem_write), 32'h0);
        check("abort busy", 32'(busy), 32'h0);
        check("abort resp_valid", 32'(resp_valid), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        hits = 0;
        repeat (6) begin
            @(posedge clk); #1;
            hits += int'(resp_valid | mem_write | mem_read);
        end
        check("abort quiet after reset", 32'(hits), 32'h0);
        run_access(0, 3'b010, 32'h0000_0020, 32'h0, g_rd, g_err, g_lat, g_nrd, g_nwr);
        check_access("post_reset w8", g_rd, g_err, g_lat, g_nrd, g_nwr, 32'h8, 0, 2, 1, 0);
        run_access(0, 3'b010, 32'h0000_0024, 32'h0, g_rd, g_err, g_lat, g_nrd, g_nwr);
        check_access("post_reset w9", g_rd, g_err, g_lat, g_nrd, g_nwr, 32'h9, 0, 2, 1, 0);

        // Randomized accesses near the bottom and top of memory.
        for (int n = 0; n < 300; n++) begin
            r_we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) begin
                case ($urandom_range(0, 2))
                    0:       r_f3 = 3'b011;
                    1:       r_f3 = 3'b110;
                    default: r_f3 = 3'b111;
                endcase
            end else if (r_we) begin
                r_f3 = 3'($urandom_range(0, 2));
            end else begin
                case ($urandom_range(0, 4))
                    0:       r_f3 = 3'b000;
                    1:       r_f3 = 3'b001;
                    2:       r_f3 = 3'b010;
                    3:       r_f3 = 3'b100;
                    default: r_f3 = 3'b101;
                endcase
            end
            r_addr = $urandom_range(0, 1) ? 32'($urandom_range(0, 127)) : 32'($urandom_range(2032, 2047));
            if ($urandom_range(0, 7) == 0) r_addr |= $urandom() & 32'hFFFF_F800;
            r_wd = $urandom();
            run_access(r_we, r_f3, r_addr, r_wd, g_rd, g_err, g_lat, g_nrd, g_nwr);
            model(r_we, r_f3, r_addr, r_wd, e_rd, e_err, e_lat, e_nrd, e_nwr);
            check_access($sformatf("rnd%0d", n), g_rd, g_err, g_lat, g_nrd, g_nwr,
                         e_rd, e_err, e_lat, e_nrd, e_nwr);
        end

        @(posedge clk); #1;
        nbad = 0;
        for (int w = 0; w < 512; w++) begin
            if (mem[w] !== {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]}) nbad++;
        end
        check("final memory words differing", 32'(nbad), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lsu_mem_sequencer.md
Name: lsu_mem_sequencer

Overview:
- Sits between the core's execute stage and the word-only data memory (word-addressed, combinational read, no byte enables).
- Converts RV32I loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) into sequences of whole-word memory reads and writes.
- Performs read-modify-write for sub-word stores, and byte-lane extraction with sign or zero extension for loads.
- Stalls the core through `busy` until each access completes.

Parameters:
- Width, 32, data and byte-address width. Fixed at 32; other values are unsupported.
- MemDepthLog2, 9, log2 of memory depth in words. Word index = byte_addr[MemDepthLog2+1:2].

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  access request; sampled only while busy=0.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
- req_addr  in  Width  byte address.
- req_wdata  in  Width  store data; low bytes are used for B/H.
- busy  out  1  high in every state other than IDLE.
- resp_valid  out  1  one-cycle pulse when the access completes.
- resp_rdata  out  Width  extended load data; 0 for stores.
- misalign_err  out  1  valid with resp_valid.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_addr  out  Width  word index, zero-extended.
- mem_wdata  out  Width  merged store word.
- mem_rdata  in  Width  memory read data; combinational, same cycle.

Behaviour:
- Reset: clock and reset ports follow the codebase convention (clk, rst_n). Reset is asynchronous and active-low; while rst_n=0 the FSM is IDLE and every output and internal buffer is 0. Asserting reset mid-operation abandons the access: no further strobes and no resp_valid. A partially completed split store is not rolled back.
- Strobes: mem_read and mem_write are never high together. In any state with no strobe, mem_addr and mem_wdata are 0.
- Decode at accept (IDLE, req_valid=1):
  - size = 1/2/4 bytes; off = addr[1:0]; w0 = word index; w1 = (w0+1) mod 2^MemDepthLog2 (wrap-around is required).
  - span = (off + size > 4).
  - Illegal funct3 (011, 110, 111) → go straight to DONE with misalign_err=1 and no memory access.
- States:
  - IDLE: on accept, latch the request. A full-word aligned store goes to WR0; everything else goes to RD0.
  - RD0: mem_read=1, mem_addr=w0, buf0<=mem_rdata. Next: RD1 if span, else WR0 if store, else DONE.
  - RD1: mem_read=1, mem_addr=w1, buf1<=mem_rdata. Next: WR0 if store, else DONE.
  - WR0: mem_write=1, mem_addr=w0, mem_wdata=merged low word. Next: WR1 if span, else DONE.
  - WR1: mem_write=1, mem_addr=w1, mem_wdata=merged high word. Next: DONE.
  - DONE: resp_valid=1 for one cycle, then return to IDLE. A new request is accepted at the earliest in the following IDLE cycle.
- Merge and extract use the 64-bit value {buf1, buf0} with shift sh = off*8.
  - Store: merged = (buf & ~(mask<<sh)) | ((wdata & mask)<<sh).
  - Load: raw = (buf>>sh) & mask. B/H sign-extend from bit 7/15; BU/HU zero-extend.
- Latency from the accept edge to resp_valid:
  - aligned LW/LB/LH: 2 cycles
  - aligned SW: 2 cycles
  - aligned SB/SH: 3 cycles
  - split load: 3 cycles
  - split store: 5 cycles
- req_* inputs are ignored while busy=1.

Optional Feature:
- Macro: LSU_MISALIGN_SPLIT_EN.
- Defined: accesses with span=1 are split across w0/w1 as described above; misalign_err=0 for all legal funct3.
- Undefined: any access with off not a multiple of size skips all memory states and goes IDLE→DONE with misalign_err=1 and resp_rdata=0. RD1 and WR1 are still present in the FSM but unreachable.

Decomposition:
- Shared package lsu_pkg holds:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU
  - the state encoding (IDLE, RD0, RD1, WR0, WR1, DONE), 3 bits
  - size/mask helper constants
- One combinational sub-module, lsu_lane_align: inputs {buf1, buf0}, off, funct3, wdata; outputs merged low/high store words and the extended load value. The FSM, buffers and strobes stay in the top module.

Test Plan:
- Memory word k = k initially. LW 0x0C → mem_read with mem_addr=3 for one cycle; resp_rdata=0x00000003 two cycles after accept.
- SW 0x80FF7F01 @0x10 → no read, a single write of word 4; then LB 0x11 → 0x0000007F, LB 0x13 → 0xFFFFFF80, LBU 0x13 → 0x00000080, LHU 0x12 → 0x000080FF.
- SB 0xAA @0x12 → read word 4, then write 0x80AA7F01 to word 4; resp after 3 cycles.
- LSU_MISALIGN_SPLIT_EN defined, word3=3, word4=0x80AA7F01: LW 0x0E → reads words 3 then 4, resp_rdata=0x7F010000, misalign_err=0. Undefined: same request → no strobes, misalign_err=1.
- Split enabled, SH 0xBEEF @0x7FF → writes word 511 (top byte=0xEF) and then word 0 (low byte=0xBE), confirming wrap-around.
- rst_n pulled low during RD1 of a split store → strobes drop immediately, busy=0, no resp_valid, no write occurs. A request issued after reset completes normally.
